// File: rtl/convolver_ctrl_pkg.sv
// Shared definitions for the convolver controller: counter width, default tap
// count and the controller state encoding.
package convolver_ctrl_pkg;

    localparam int ADDR_FIFO    = 8;
    localparam int TAPS_DEFAULT = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD_FILT,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

endpackage

// File: rtl/convolver_ctrl_valid_delay.sv
// LAT-deep 1-bit shift register aligning mac_enable with the convolver's MAC
// result (output_valid).
module valid_delay #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [LAT-1:0] sr_q;
    logic [LAT-1:0] sr_d;
    logic [LAT:0]   shifted;

    always_comb begin
        shifted = {sr_q, din};
        sr_d    = shifted[LAT-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr_q <= '0;
        else      sr_q <= sr_d;
    end

    assign dout = sr_q[LAT-1];

endmodule

// File: rtl/convolver_ctrl.sv
// Job controller for a 3x3 convolver: clears line buffers, loads TAPS
// coefficients, streams an image and flags valid MAC results.
module convolver_ctrl
    import convolver_ctrl_pkg::*;
#(
    parameter int MAC_LAT = 1,
    parameter int TAPS    = TAPS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_FIFO-1:0] row_length,
    input  logic [ADDR_FIFO-1:0] num_rows,
    input  logic                 filt_valid,
    output logic                 filt_ready,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic                 shifting_filter,
    output logic                 shifting_line,
    output logic                 line_buffer_reset,
    output logic                 mac_enable,
    output logic                 output_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int TW = $clog2(TAPS + 1);
    localparam int DW = $clog2(MAC_LAT + 1) + 1;
    localparam logic [ADDR_FIFO-1:0] ONE   = ADDR_FIFO'(1);
    localparam logic [ADDR_FIFO-1:0] TWO   = ADDR_FIFO'(2);
    localparam logic [ADDR_FIFO-1:0] THREE = ADDR_FIFO'(3);

    state_e               state_q, state_d;
    logic [TW-1:0]        tap_q, tap_d;
    logic [ADDR_FIFO-1:0] col_q, col_d;
    logic [ADDR_FIFO-1:0] row_q, row_d;
    logic [ADDR_FIFO-1:0] rl_q, rl_d;
    logic [ADDR_FIFO-1:0] nr_q, nr_d;
    logic [DW-1:0]        drain_q, drain_d;
    logic                 mac_q, mac_d;

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        col_d   = col_q;
        row_d   = row_q;
        rl_d    = rl_q;
        nr_d    = nr_q;
        drain_d = drain_q;
        mac_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rl_d = row_length;
                    nr_d = num_rows;
                    // Degenerate images produce no windows: finish without touching the datapath
                    if (row_length >= THREE && num_rows >= THREE) state_d = S_CLEAR;
                    else                                          state_d = S_DONE;
                end
            end
            S_CLEAR: begin
                tap_d   = '0;
                col_d   = '0;
                row_d   = '0;
                drain_d = '0;
                state_d = S_LOAD_FILT;
            end
            S_LOAD_FILT: begin
                if (filt_valid) begin
                    tap_d = tap_q + TW'(1);
                    if (tap_q == TW'(TAPS - 1)) state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (pix_valid) begin
                    // Full 3x3 window exists once two prior rows and columns are buffered
                    mac_d = (row_q >= TWO) && (col_q >= TWO);
                    if (col_q == rl_q - ONE) begin
                        col_d = '0;
                        row_d = row_q + ONE;
                        if (row_q == nr_q - ONE) state_d = S_DRAIN;
                    end else begin
                        col_d = col_q + ONE;
                    end
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + DW'(1);
                if (drain_q == DW'(MAC_LAT)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tap_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            rl_q    <= '0;
            nr_q    <= '0;
            drain_q <= '0;
            mac_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            col_q   <= col_d;
            row_q   <= row_d;
            rl_q    <= rl_d;
            nr_q    <= nr_d;
            drain_q <= drain_d;
            mac_q   <= mac_d;
        end
    end

    assign busy              = (state_q != S_IDLE);
    assign done              = (state_q == S_DONE);
    assign line_buffer_reset = (state_q == S_CLEAR);
    assign filt_ready        = (state_q == S_LOAD_FILT);
    assign pix_ready         = (state_q == S_STREAM);
    assign shifting_filter   = filt_valid & filt_ready;
    assign shifting_line     = pix_valid & pix_ready;
    assign mac_enable        = mac_q;

    valid_delay #(
        .LAT(MAC_LAT)
    ) u_valid_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (mac_q),
        .dout (output_valid)
    );

endmodule

// File: tb/tb_convolver_ctrl.sv
// Directed bench for convolver_ctrl: job sequences with hand-computed counts
// of handshakes, MAC enables and output_valid pulses.
module tb_convolver_ctrl;
    import convolver_ctrl_pkg::*;

    localparam int MAC_LAT = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [ADDR_FIFO-1:0] row_length;
    logic [ADDR_FIFO-1:0] num_rows;
    logic                 filt_valid, filt_ready;
    logic                 pix_valid, pix_ready;
    logic                 shifting_filter, shifting_line, line_buffer_reset;
    logic                 mac_enable, output_valid, busy, done;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc = 0;
    int ov_cnt, mac_cnt, sf_cnt, sl_cnt, lbr_cnt, done_cnt, busy_cnt, viol;
    int first_ov_cyc, xfer13_cyc;
    bit prev_xfer = 1'b0;

    always #5 clk = ~clk;

    convolver_ctrl #(
        .MAC_LAT (MAC_LAT),
        .TAPS    (9)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .row_length        (row_length),
        .num_rows          (num_rows),
        .filt_valid        (filt_valid),
        .filt_ready        (filt_ready),
        .pix_valid         (pix_valid),
        .pix_ready         (pix_ready),
        .shifting_filter   (shifting_filter),
        .shifting_line     (shifting_line),
        .line_buffer_reset (line_buffer_reset),
        .mac_enable        (mac_enable),
        .output_valid      (output_valid),
        .busy              (busy),
        .done              (done)
    );

    // Observe every cycle mid-period; inputs change just after the rising edge
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (shifting_line !== (pix_valid & pix_ready))     viol++;
            if (shifting_filter !== (filt_valid & filt_ready)) viol++;
            if (filt_ready && pix_ready)                       viol++;
            if (pix_ready && sf_cnt < 9)                       viol++;
            if (mac_enable && !prev_xfer)                      viol++;
            prev_xfer = pix_valid & pix_ready;
            if (output_valid) begin
                if (ov_cnt == 0) first_ov_cyc = cyc;
                ov_cnt++;
            end
            if (shifting_line) begin
                sl_cnt++;
                if (sl_cnt == 13) xfer13_cyc = cyc;
            end
            if (shifting_filter)   sf_cnt++;
            if (mac_enable)        mac_cnt++;
            if (line_buffer_reset) lbr_cnt++;
            if (done)              done_cnt++;
            if (busy)              busy_cnt++;
        end else begin
            prev_xfer = 1'b0;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        ov_cnt = 0; mac_cnt = 0; sf_cnt = 0; sl_cnt = 0; lbr_cnt = 0;
        done_cnt = 0; busy_cnt = 0; viol = 0;
        first_ov_cyc = -1; xfer13_cyc = -1;
    endtask

    function automatic int outs();
        return int'({busy, done, filt_ready, pix_ready, shifting_filter, shifting_line,
                     line_buffer_reset, mac_enable, output_valid});
    endfunction

    // Called at posedge+1; returns at posedge+1 after done was seen or abort point hit
    task automatic run(input int rl, input int nr, input bit fgap, input bit pgap,
                       input bit poke, input int abort_at);
        bit poked = 1'b0;
        clear_counts();
        row_length = ADDR_FIFO'(rl);
        num_rows   = ADDR_FIFO'(nr);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 600; i++) begin
            filt_valid = fgap ? ((i % 3) != 2) : 1'b1;
            pix_valid  = pgap ? ((i % 3) != 2) : 1'b1;
            if (poke && !poked && sl_cnt == 5) begin
                start      = 1'b1;
                row_length = ADDR_FIFO'(3);
                poked      = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done_cnt != 0) break;
            if (abort_at != 0 && sl_cnt >= abort_at) break;
        end
        start = 1'b0;
        if (abort_at == 0) begin
            filt_valid = 1'b0;
            pix_valid  = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; row_length = '0; num_rows = '0;
        filt_valid = 1'b0; pix_valid = 1'b0;
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", outs(), 0);

        // 5x5, back-to-back coefficients and pixels
        run(5, 5, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("j1_output_valid", ov_cnt, 9);
        chk("j1_mac_enable", mac_cnt, 9);
        chk("j1_shift_filter", sf_cnt, 9);
        chk("j1_shift_line", sl_cnt, 25);
        chk("j1_lb_reset", lbr_cnt, 1);
        chk("j1_done", done_cnt, 1);
        chk("j1_busy_cycles", busy_cnt, 38);
        chk("j1_first_latency", first_ov_cyc - xfer13_cyc, MAC_LAT + 1);
        chk("j1_protocol", viol, 0);
        chk("j1_idle_after", outs(), 0);

        // 5x5 with pix_valid low every third cycle
        run(5, 5, 1'b0, 1'b1, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("j2_output_valid", ov_cnt, 9);
        chk("j2_mac_enable", mac_cnt, 9);
        chk("j2_shift_line", sl_cnt, 25);
        chk("j2_done", done_cnt, 1);
        chk("j2_protocol", viol, 0);

        // Degenerate 2x5 job
        run(2, 5, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("j3_busy_cycles", busy_cnt, 1);
        chk("j3_done", done_cnt, 1);
        chk("j3_activity", sf_cnt + sl_cnt + lbr_cnt + mac_cnt + ov_cnt, 0);

        // start re-pulsed with row_length=3 during STREAM
        run(5, 5, 1'b0, 1'b0, 1'b1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("j4_output_valid", ov_cnt, 9);
        chk("j4_shift_line", sl_cnt, 25);
        chk("j4_busy_cycles", busy_cnt, 38);
        chk("j4_done", done_cnt, 1);
        chk("j4_idle_after", outs(), 0);

        // Reset mid-job after the 10th pixel
        run(5, 5, 1'b0, 1'b0, 1'b0, 10);
        chk("j5_pixels_before_reset", sl_cnt, 10);
        rst = 1'b0;
        #1;
        chk("j5_outputs_in_reset", outs(), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        filt_valid = 1'b0;
        pix_valid  = 1'b0;
        @(posedge clk); #1;
        chk("j5_idle_after_reset", outs(), 0);
        run(4, 4, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("j5_output_valid", ov_cnt, 4);
        chk("j5_shift_line", sl_cnt, 16);
        chk("j5_lb_reset", lbr_cnt, 1);
        chk("j5_busy_cycles", busy_cnt, 29);
        chk("j5_done", done_cnt, 1);

        // 3-wide by 4-high job with gaps in the coefficient stream
        run(3, 4, 1'b1, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("j6_shift_filter", sf_cnt, 9);
        chk("j6_output_valid", ov_cnt, 2);
        chk("j6_shift_line", sl_cnt, 12);
        chk("j6_protocol", viol, 0);
        chk("j6_done", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
